gol_matrix_driver: RTL

//  Consumer end of the GOL grid interface: takes each evolved 64-bit generation and scans it onto an
//  8x8 LED matrix. Row data goes out through an external serial-in shift register (595-style).

---
 rtl/gol_pkg.sv | 21 ++
 rtl/gol_matrix_driver_if.sv | 9 +
 rtl/gol_shift_out.sv | 67 ++++++
 rtl/gol_matrix_driver.sv | 119 +++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and geometry for the GOL matrix driver: grid layout, FSM states
// and a row-slice helper.
package gol_pkg;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int GRID_W = ROWS * COLS;
  localparam int ROW_W  = $clog2(ROWS);

  typedef logic [GRID_W-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LATCH,
    DISPLAY
  } drv_state_t;

  function automatic logic [COLS-1:0] row_bits(input grid_t g, input logic [ROW_W-1:0] r);
    return g[r*COLS +: COLS];
  endfunction
endpackage

// File: rtl/gol_matrix_driver_if.sv
// Generation handshake between the GOL core (master) and the matrix driver (slave).
interface gol_matrix_driver_if;
  gol_pkg::grid_t grid_in;
  logic           grid_valid;
  logic           grid_ready;

  modport master (output grid_in, output grid_valid, input grid_ready);
  modport slave  (input grid_in, input grid_valid, output grid_ready);
endinterface

// File: rtl/gol_shift_out.sv
// Serialises one COLS-bit row MSB-first onto a 595-style shift register.
// sr_clk is low for SCLK_DIV cycles then high for SCLK_DIV cycles per bit.
module gol_shift_out #(
  parameter int COLS     = 8,
  parameter int SCLK_DIV = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [COLS-1:0] i_row,
  output logic            o_sr_clk,
  output logic            o_sr_data,
  output logic            o_done
);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic             r_busy;
  logic             r_phase;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic [COLS-1:0]  r_sh;

  logic w_half_end;
  logic w_last_bit;

  assign w_half_end = (r_div == DIV_W'(SCLK_DIV - 1));
  assign w_last_bit = (r_bit == BIT_W'(COLS - 1));

  // Asserted during the final high half-period so the FSM leaves LOAD on its closing edge.
  assign o_done    = r_busy & r_phase & w_half_end & w_last_bit;
  assign o_sr_clk  = r_phase;
  assign o_sr_data = r_busy & r_sh[COLS-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy  <= 1'b0;
      r_phase <= 1'b0;
      r_div   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_phase <= 1'b0;
      r_div   <= '0;
      r_bit   <= '0;
      r_sh    <= i_row;
    end else if (r_busy) begin
      if (w_half_end) begin
        r_div <= '0;
        if (!r_phase) begin
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (w_last_bit) begin
            r_busy <= 1'b0;
          end else begin
            r_bit <= r_bit + BIT_W'(1);
            r_sh  <= {r_sh[COLS-2:0], 1'b0};
          end
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end
endmodule

// File: rtl/gol_matrix_driver.sv
// Double-buffered 8x8 LED matrix scanner: accepts GOL generations over a
// valid/ready handshake and scans the front buffer row by row.
module gol_matrix_driver
  import gol_pkg::*;
#(
  parameter int SCLK_DIV = 2,
  parameter int DWELL    = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  gol_matrix_driver_if.slave    grid_if,
  output logic [ROWS-1:0]       row_sel,
  output logic                  sr_clk,
  output logic                  sr_data,
  output logic                  sr_latch,
  output logic                  frame_done
);
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  drv_state_t       r_state;
  grid_t            r_front;
  grid_t            r_back;
  logic             r_back_full;
  logic             r_ready;
  logic [ROW_W-1:0] r_row;
  logic [DW_W-1:0]  r_dwell;
  logic             r_frame_done;

  drv_state_t       w_state_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic             w_start;
  logic             w_wrap;
  logic             w_dwell_last;
  logic             w_swap;
  logic             w_cap;
  logic             w_sh_done;
  logic [COLS-1:0]  w_load_row;

  assign w_dwell_last = (r_dwell == DW_W'(DWELL - 1));
  assign w_cap        = grid_if.grid_valid & r_ready;
  // Swap only on entry from IDLE or at frame wrap, so a frame never mixes generations.
  assign w_swap       = r_back_full & ((r_state == IDLE) | w_wrap);
  assign w_load_row   = row_bits(w_swap ? r_back : r_front, w_row_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_start     = 1'b0;
    w_wrap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_back_full) begin
          w_state_nxt = LOAD;
          w_row_nxt   = '0;
          w_start     = 1'b1;
        end
      end
      LOAD: begin
        if (w_sh_done) w_state_nxt = LATCH;
      end
      LATCH: w_state_nxt = DISPLAY;
      DISPLAY: begin
        if (w_dwell_last) begin
          w_state_nxt = LOAD;
          w_start     = 1'b1;
          if (r_row == ROW_W'(ROWS - 1)) begin
            w_wrap    = 1'b1;
            w_row_nxt = '0;
          end else begin
            w_row_nxt = r_row + ROW_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_front      <= '0;
      r_back       <= '0;
      r_back_full  <= 1'b0;
      r_ready      <= 1'b1;
      r_row        <= '0;
      r_dwell      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_dwell      <= (r_state == DISPLAY && !w_dwell_last) ? r_dwell + DW_W'(1) : '0;
      r_frame_done <= w_wrap;
      if (w_cap) r_back <= grid_if.grid_in;
      if (w_swap) r_front <= r_back;
      if (w_cap) r_back_full <= 1'b1;
      else if (w_swap) r_back_full <= 1'b0;
      r_ready <= !(w_cap | (r_back_full & !w_swap));
    end
  end

  gol_shift_out #(
    .COLS     (COLS),
    .SCLK_DIV (SCLK_DIV)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_row     (w_load_row),
    .o_sr_clk  (sr_clk),
    .o_sr_data (sr_data),
    .o_done    (w_sh_done)
  );

  // Row drive comes straight from state so an async reset blanks the matrix at once.
  assign row_sel            = (r_state == DISPLAY) ? ({{(ROWS-1){1'b0}}, 1'b1} << r_row) : '0;
  assign sr_latch           = (r_state == LATCH);
  assign frame_done         = r_frame_done;
  assign grid_if.grid_ready = r_ready;
endmodule
